super_mux_pipe: RTL and testbench
=================================

Name: super_mux_pipe

Overview:
- Parametrised successor to the 2:1 regular/super data select: one regular source plus CHANNELS priority-ordered override sources.
- The selection result passes through a STAGES-deep pipeline with valid/ready handshake and flush.
- Used in the parallel MIPS/BTB datapath for forwarding and redirect selection where the consumer can stall.
- Reports which source won, per beat, alongside the data.

Parameters:
- WIDTH, 32, data width of every source and of Out.
- CHANNELS, 4, number of override (super) sources; legal range 1..15.
- STAGES, 1, number of register stages between selection and Out; legal range 1..4.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- RegularData  input  WIDTH  default source.
- SuperData  input  CHANNELS*WIDTH  override sources; channel k occupies bits [k*WIDTH +: WIDTH].
- SuperSel  input  CHANNELS  override request per channel.
- InValid  input  1  input beat valid.
- InReady  output  1  beat is accepted when InValid && InReady at the clock edge.
- Flush  input  1  discards all beats held in the pipeline.
- Out  output  WIDTH  selected data at the last stage.
- OutSrc  output  4  source of Out: 0 = regular, k+1 = super channel k.
- OutValid  output  1  Out/OutSrc hold a valid beat.
- OutReady  input  1  consumer accepts when OutValid && OutReady.
- SelErr  output  1  present only with SUPER_MUX_ONEHOT_CHK_EN.

Behaviour:
- Clock and reset: one clock, Clk. Rst_n is asynchronous, active-low. While Rst_n = 0:
  - all stage valid bits are 0, Out = 0, OutSrc = 0, SelErr = 0;
  - InReady = 0 and OutValid = 0.
- Selection (combinational, at the input):
  - The lowest-index channel k with SuperSel[k] = 1 wins; data = SuperData channel k, src = k+1.
  - If SuperSel is all zero: data = RegularData, src = 0.
- Pipeline:
  - Stage i holds {data, src, valid}; stage STAGES-1 drives Out/OutSrc/OutValid.
  - Stage i advances when it is empty or stage i+1 advances; the last stage advances when OutReady = 1 or it is empty.
  - InReady = !Flush && (stage 0 empty || stage 0 advances). The ready chain is combinational.
- Latency and throughput:
  - An accepted beat appears at OutValid exactly STAGES cycles later when no backpressure occurs.
  - Sustained throughput is one beat per cycle while OutReady = 1.
- Stall: when a stage does not advance, its data/src/valid hold unchanged. Out is stable while OutValid && !OutReady. No beat is lost or duplicated.
- Bubbles: a stage that advances with no incoming beat clears its valid bit. Its data register may hold stale contents; a bench checks Out only when OutValid = 1.
- Flush:
  - Synchronous; clears every valid bit at the next edge.
  - Takes priority over accept: InReady = 0 during Flush, so no beat is captured that cycle.
  - OutValid = 0 from the cycle after Flush.
  - Out/OutSrc data registers are not cleared.
- Simultaneous events:
  - Flush with OutValid && OutReady: the output beat is consumed, then the pipeline is empty.
  - Flush with InValid: the input beat is dropped.
- Reset mid-operation: all beats are dropped immediately (asynchronous). The pipeline restarts empty after Rst_n deasserts. InReady rises in the first cycle after deassertion.
- Width rules: OutSrc is fixed at 4 bits; unused upper bits are 0. CHANNELS > 15 is illegal and is rejected at elaboration.

Optional Feature:
- Macro: SUPER_MUX_ONEHOT_CHK_EN.
- Defined:
  - The SelErr output exists. SelErr is registered and sticky.
  - It sets at the edge where a beat is accepted with more than one SuperSel bit set.
  - It clears only on reset or Flush; Flush wins over a same-cycle set.
  - Selection still follows the lowest-index priority.
- Undefined: no SelErr port and no check logic; all other behaviour is identical.

Test Plan:
- Reset/priority: CHANNELS=4, STAGES=1.
  - Release reset, then RegularData=0x11111111, SuperSel=0 -> next cycle Out=0x11111111, OutSrc=0, OutValid=1.
  - SuperSel=4'b1010 -> Out=SuperData ch1, OutSrc=2.
- Latency/throughput: STAGES=3, OutReady=1, 8 back-to-back beats 0..7 -> OutValid rises 3 cycles after the first accept; Out = 0..7 on consecutive cycles.
- Backpressure: STAGES=2, OutReady=0 for 5 cycles while InValid=1.
  - Exactly 2 beats accepted, then InReady=0; Out held stable.
  - Releasing OutReady yields the beats in order, with no loss or duplication.
- Flush: 2 beats in flight, then Flush=1 with InValid=1 -> InReady=0 that cycle, OutValid=0 next cycle; next accepted beat emerges after STAGES cycles.
- Async reset: assert Rst_n=0 mid-clock with a full pipeline -> OutValid=0 and Out=0 immediately, before the next edge.
- SUPER_MUX_ONEHOT_CHK_EN defined: accept a beat with SuperSel=4'b0011 -> SelErr=1 at the next edge and stays 1; Flush -> SelErr=0. Undefined build compiles without the SelErr port.

Source files
------------

// File: rtl/super_mux_pipe.sv
// super_mux_pipe: priority select of one regular source and CHANNELS override
// sources, followed by a STAGES-deep valid/ready pipeline with flush.
// OutSrc reports the winning source: 0 = regular, k+1 = override channel k.
// Optional sticky multi-select detector: define SUPER_MUX_ONEHOT_CHK_EN.
module super_mux_pipe #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int STAGES   = 1
) (
   input  logic                      Clk,
   input  logic                      Rst_n,
   input  logic [WIDTH-1:0]          RegularData,
   input  logic [CHANNELS*WIDTH-1:0] SuperData,
   input  logic [CHANNELS-1:0]       SuperSel,
   input  logic                      InValid,
   output logic                      InReady,
   input  logic                      Flush,
   output logic [WIDTH-1:0]          Out,
   output logic [3:0]                OutSrc,
   output logic                      OutValid,
   input  logic                      OutReady
`ifdef SUPER_MUX_ONEHOT_CHK_EN
   ,
   output logic                      SelErr
`endif
);

   // OutSrc is 4 bits wide, so at most 15 override channels can be named.
   generate
      if (CHANNELS < 1 || CHANNELS > 15 || STAGES < 1 || STAGES > 4) begin : g_bad_param
         $error("super_mux_pipe: CHANNELS must be 1..15 and STAGES 1..4");
      end
   endgenerate

   logic [WIDTH-1:0]              sel_data;
   logic [3:0]                    sel_src;
   logic [STAGES:0]               go;
   logic                          acc;
   logic [STAGES-1:0]             vld_q, vld_d;
   logic [STAGES-1:0][WIDTH-1:0]  data_q, data_d;
   logic [STAGES-1:0][3:0]        src_q, src_d;

   // Lowest-index requesting channel wins; scan high to low so it lands last.
   always_comb begin
      sel_data = RegularData;
      sel_src  = 4'd0;
      for (int k = CHANNELS-1; k >= 0; k--) begin
         if (SuperSel[k]) begin
            sel_data = SuperData[k*WIDTH +: WIDTH];
            sel_src  = 4'(k+1);
         end
      end
   end

   // Ready chain: a stage moves when empty or when its successor moves.
   always_comb begin
      go         = '0;
      go[STAGES] = OutReady;
      for (int i = STAGES-1; i >= 0; i--) go[i] = !vld_q[i] || go[i+1];
   end

   assign InReady = Rst_n && !Flush && go[0];
   assign acc     = InValid && InReady;

   // Next state of the stage registers; flush only kills the valid bits.
   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      src_d  = src_q;
      if (go[0]) begin
         vld_d[0]  = acc;
         data_d[0] = sel_data;
         src_d[0]  = sel_src;
      end
      for (int i = 1; i < STAGES; i++) begin
         if (go[i]) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
            src_d[i]  = src_q[i-1];
         end
      end
      if (Flush) vld_d = '0;
   end

   // Stage registers.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         vld_q  <= '0;
         data_q <= '0;
         src_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
         src_q  <= src_d;
      end
   end

   assign Out      = data_q[STAGES-1];
   assign OutSrc   = src_q[STAGES-1];
   assign OutValid = vld_q[STAGES-1];

`ifdef SUPER_MUX_ONEHOT_CHK_EN
   logic multi;
   logic err_q, err_d;

   assign multi = |(SuperSel & (SuperSel - CHANNELS'(1)));

   // Sticky error on any accepted multi-select beat; flush clears it.
   always_comb begin
      err_d = err_q;
      if (acc && multi) err_d = 1'b1;
      if (Flush)        err_d = 1'b0;
   end

   // Error flag register.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign SelErr = err_q;
`endif

endmodule

// File: tb/tb_super_mux_pipe.sv
// Directed bench: three instances (STAGES = 1, 2, 3), CHANNELS = 4, WIDTH = 32.
module tb_super_mux_pipe;
   logic Clk = 1'b0;
   logic Rst_n = 1'b0;
   always #5 Clk = ~Clk;

   logic [31:0]  rd   [3];
   logic [127:0] sd   [3];
   logic [3:0]   ss   [3];
   logic         iv   [3];
   logic         fl   [3];
   logic         ordy [3];
   logic         irdy [3];
   logic         ov   [3];
   logic [31:0]  out  [3];
   logic [3:0]   osrc [3];
`ifdef SUPER_MUX_ONEHOT_CHK_EN
   logic         serr [3];
`endif

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         super_mux_pipe #(.WIDTH(32), .CHANNELS(4), .STAGES(g+1)) u_dut (
            .Clk(Clk), .Rst_n(Rst_n),
            .RegularData(rd[g]), .SuperData(sd[g]), .SuperSel(ss[g]),
            .InValid(iv[g]), .InReady(irdy[g]), .Flush(fl[g]),
            .Out(out[g]), .OutSrc(osrc[g]), .OutValid(ov[g]), .OutReady(ordy[g])
`ifdef SUPER_MUX_ONEHOT_CHK_EN
            , .SelErr(serr[g])
`endif
         );
      end
   endgenerate

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   logic [31:0] accq [$];

   initial begin
      for (int i = 0; i < 3; i++) begin
         rd[i] = '0; sd[i] = '0; ss[i] = '0; iv[i] = 1'b0; fl[i] = 1'b0; ordy[i] = 1'b1;
      end
      step(); step();
      // reset state
      chk("rst_out",  out[0], 32'h0);
      chk("rst_ov",   32'(ov[0]), 32'h0);
      chk("rst_irdy", 32'(irdy[0]), 32'h0);
      chk("rst_src",  32'(osrc[0]), 32'h0);
`ifdef SUPER_MUX_ONEHOT_CHK_EN
      chk("rst_serr", 32'(serr[0]), 32'h0);
`endif
      Rst_n = 1'b1;
      #1;
      chk("irdy_after_rst", 32'(irdy[0]), 32'h1);

      // ---- priority, STAGES=1 ----
      rd[0] = 32'h11111111; ss[0] = 4'b0000; iv[0] = 1'b1; ordy[0] = 1'b1;
      sd[0] = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
      step();
      chk("reg_out", out[0], 32'h11111111);
      chk("reg_src", 32'(osrc[0]), 32'd0);
      chk("reg_ov",  32'(ov[0]), 32'd1);
      ss[0] = 4'b1010; step();
      chk("p1010_out", out[0], 32'hB1B1B1B1);
      chk("p1010_src", 32'(osrc[0]), 32'd2);
      ss[0] = 4'b1000; step();
      chk("p1000_out", out[0], 32'hD3D3D3D3);
      chk("p1000_src", 32'(osrc[0]), 32'd4);
      ss[0] = 4'b0001; step();
      chk("p0001_out", out[0], 32'hA0A0A0A0);
      chk("p0001_src", 32'(osrc[0]), 32'd1);
      ss[0] = 4'b0000; iv[0] = 1'b0; step();
      chk("bubble_ov", 32'(ov[0]), 32'd0);

      // ---- stall, STAGES=1 ----
      iv[0] = 1'b1; rd[0] = 32'h22; step();
      chk("st_out0", out[0], 32'h22);
      ordy[0] = 1'b0; rd[0] = 32'h33; #1;
      chk("st_irdy0", 32'(irdy[0]), 32'd0);
      step();
      chk("st_hold_out", out[0], 32'h22);
      chk("st_hold_ov",  32'(ov[0]), 32'd1);
      ordy[0] = 1'b1; #1;
      chk("st_irdy1", 32'(irdy[0]), 32'd1);
      step();
      chk("st_out1", out[0], 32'h33);
      iv[0] = 1'b0; step();
      chk("st_ov_end", 32'(ov[0]), 32'd0);

      // ---- latency/throughput, STAGES=3 ----
      ordy[2] = 1'b1;
      for (int c = 0; c < 12; c++) begin
         chk($sformatf("lat_ov%0d", c), 32'(ov[2]), 32'((c >= 3 && c <= 10) ? 1 : 0));
         if (c >= 3 && c <= 10) chk($sformatf("lat_out%0d", c), out[2], 32'(c-3));
         iv[2] = (c < 8);
         rd[2] = 32'(c);
         step();
      end
      iv[2] = 1'b0;

      // ---- backpressure, STAGES=2 ----
      ordy[1] = 1'b0;
      for (int c = 0; c < 5; c++) begin
         iv[1] = 1'b1; rd[1] = 32'h100 + 32'(c); #1;
         if (irdy[1]) accq.push_back(rd[1]);
         if (c >= 2) begin
            chk($sformatf("bp_hold_out%0d", c), out[1], 32'h100);
            chk($sformatf("bp_hold_ov%0d", c), 32'(ov[1]), 32'd1);
         end
         step();
      end
      chk("bp_nacc", 32'(accq.size()), 32'd2);
      if (accq.size() == 2) begin
         chk("bp_acc0", accq[0], 32'h100);
         chk("bp_acc1", accq[1], 32'h101);
      end
      iv[1] = 1'b0; ordy[1] = 1'b1; #1;
      chk("bp_rel_out0", out[1], 32'h100);
      step();
      chk("bp_rel_out1", out[1], 32'h101);
      chk("bp_rel_ov1",  32'(ov[1]), 32'd1);
      step();
      chk("bp_rel_empty", 32'(ov[1]), 32'd0);

      // ---- flush, STAGES=2 ----
      iv[1] = 1'b1; rd[1] = 32'h200; step();
      rd[1] = 32'h201; step();
      fl[1] = 1'b1; rd[1] = 32'h202; #1;
      chk("fl_irdy", 32'(irdy[1]), 32'd0);
      chk("fl_out_cons", out[1], 32'h200);
      step();
      fl[1] = 1'b0; rd[1] = 32'h203; #1;
      chk("fl_ov_after", 32'(ov[1]), 32'd0);
      chk("fl_irdy_back", 32'(irdy[1]), 32'd1);
      step();
      iv[1] = 1'b0;
      chk("fl_ov_lat1", 32'(ov[1]), 32'd0);
      step();
      chk("fl_new_ov",  32'(ov[1]), 32'd1);
      chk("fl_new_out", out[1], 32'h203);
      step();
      chk("fl_new_end", 32'(ov[1]), 32'd0);

      // ---- async reset, STAGES=3 full ----
      ordy[2] = 1'b0;
      for (int c = 0; c < 4; c++) begin
         iv[2] = 1'b1; rd[2] = 32'h300 + 32'(c); step();
      end
      iv[2] = 1'b0;
      chk("ar_full_ov",  32'(ov[2]), 32'd1);
      chk("ar_full_out", out[2], 32'h300);
      #3 Rst_n = 1'b0;
      #1;
      chk("ar_ov",   32'(ov[2]), 32'd0);
      chk("ar_out",  out[2], 32'h0);
      chk("ar_irdy", 32'(irdy[2]), 32'd0);
      chk("ar_out0", out[0], 32'h0);
      #2 Rst_n = 1'b1;
      #1;
      chk("ar_irdy_rel", 32'(irdy[2]), 32'd1);
      step();
      chk("ar_empty", 32'(ov[2]), 32'd0);
      ordy[2] = 1'b1;

`ifdef SUPER_MUX_ONEHOT_CHK_EN
      // ---- sticky select error, STAGES=1 ----
      iv[0] = 1'b1; ss[0] = 4'b0100; step();
      chk("se_single", 32'(serr[0]), 32'd0);
      chk("se_single_src", 32'(osrc[0]), 32'd3);
      ss[0] = 4'b0011; step();
      chk("se_set", 32'(serr[0]), 32'd1);
      chk("se_out", out[0], 32'hA0A0A0A0);
      chk("se_src", 32'(osrc[0]), 32'd1);
      iv[0] = 1'b0; ss[0] = 4'b0000; step();
      chk("se_sticky", 32'(serr[0]), 32'd1);
      fl[0] = 1'b1; step();
      fl[0] = 1'b0;
      chk("se_clr", 32'(serr[0]), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
